aes_uart_controller: RTL

AES_UART_CONTROLLER -- requirements
Module: aes_uart_controller

---
 rtl/aes_uart_controller_pkg.sv | 19 +
 rtl/aes_uart_controller_if.sv | 30 +++
 rtl/aes_uart_controller_tx_unshift.sv | 34 +++
 rtl/aes_uart_controller.sv | 116 +++++++++++
 4 files changed

// File: rtl/aes_uart_controller_pkg.sv
// Shared encodings and sizes for the AES-to-UART block streamer.
package aes_uart_controller_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BYTE_W      = 8;
    localparam int BLOCK_W     = BLOCK_BYTES * BYTE_W;
    localparam int IDX_W       = $clog2(BLOCK_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        WAIT_AES,
        SEND,
        WAIT_TX
    } state_t;

endpackage

// File: rtl/aes_uart_controller_if.sv
// FIFO, AES-core and UART-side signals of the controller, grouped as one bus.
interface aes_uart_controller_if;
    import aes_uart_controller_pkg::*;

    logic               empty;
    logic               overflow;
    logic [BLOCK_W-1:0] block_in;
    logic               read_en;
    logic [BLOCK_W-1:0] aes_block;
    logic               aes_start;
    logic               aes_done;
    logic [BLOCK_W-1:0] aes_result;
    logic [BYTE_W-1:0]  tx_byte;
    logic               tx_start;
    logic               tx_done;
    logic               busy;
    logic               error;
    logic [15:0]        blocks_done;

    modport master (
        input  empty, overflow, block_in, aes_done, aes_result, tx_done,
        output read_en, aes_block, aes_start, tx_byte, tx_start, busy, error, blocks_done
    );

    modport slave (
        output empty, overflow, block_in, aes_done, aes_result, tx_done,
        input  read_en, aes_block, aes_start, tx_byte, tx_start, busy, error, blocks_done
    );

endinterface

// File: rtl/aes_uart_controller_tx_unshift.sv
// Holds the ciphertext and presents it one byte at a time, most significant byte first.
module tx_unshift
    import aes_uart_controller_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [BLOCK_W-1:0] i_data,
    input  logic               i_next,
    output logic [BYTE_W-1:0]  o_byte,
    output logic               o_last
);

    logic [BLOCK_W-1:0] r_data;
    logic [IDX_W-1:0]   r_idx;

    // Shifting the register left keeps the current byte in the top lane.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_idx  <= '0;
        end else if (i_next) begin
            r_data <= {r_data[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            r_idx  <= r_idx + 1'b1;
        end
    end

    assign o_byte = r_data[BLOCK_W-1 -: BYTE_W];
    assign o_last = (r_idx == IDX_W'(BLOCK_BYTES - 1));

endmodule

// File: rtl/aes_uart_controller.sv
// Pops 128-bit blocks from a FIFO, encrypts them on an AES core and streams the
// ciphertext bytes to a UART transmitter.
module aes_uart_controller
    import aes_uart_controller_pkg::*;
#(
    parameter int AES_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    aes_uart_controller_if.master bus
);

    localparam int TO_W = 16;

    state_t             r_state;
    state_t             w_next;
    logic [BLOCK_W-1:0] r_aes_block;
    logic [TO_W-1:0]    r_timeout;
    logic [TO_W-1:0]    w_timeout_inc;
    logic [15:0]        r_blocks_done;
    logic               r_error;
    logic               w_load_tx;
    logic               w_next_byte;
    logic               w_last;
    logic               w_abort;
    logic               w_block_end;
    logic [BYTE_W-1:0]  w_byte;

    assign w_timeout_inc = r_timeout + 1'b1;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_load_tx   = 1'b0;
        w_next_byte = 1'b0;
        w_abort     = 1'b0;
        w_block_end = 1'b0;
        case (r_state)
            IDLE:     if (!bus.empty) w_next = POP;
            POP:      w_next = LOAD;
            LOAD:     w_next = START;
            START:    w_next = WAIT_AES;
            WAIT_AES: begin
                if (bus.aes_done) begin
                    w_load_tx = 1'b1;
                    w_next    = SEND;
                end else if (w_timeout_inc == TO_W'(AES_TIMEOUT)) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end
            end
            SEND:     w_next = WAIT_TX;
            WAIT_TX: begin
                if (bus.tx_done) begin
                    w_next_byte = 1'b1;
                    if (w_last) begin
                        w_block_end = 1'b1;
                        w_next      = IDLE;
                    end else begin
                        w_next = SEND;
                    end
                end
            end
            default:  w_next = IDLE;
        endcase
    end

    // Timeout counts waited cycles; the abort fires as it reaches AES_TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_aes_block   <= '0;
            r_timeout     <= '0;
            r_error       <= 1'b0;
            r_blocks_done <= '0;
        end else begin
            if (r_state == LOAD) r_aes_block <= bus.block_in;
            if (r_state == START) begin
                r_timeout <= '0;
            end else if (r_state == WAIT_AES) begin
                r_timeout <= w_timeout_inc;
            end
            if (bus.overflow || w_abort) r_error <= 1'b1;
            if (w_block_end) r_blocks_done <= r_blocks_done + 16'd1;
        end
    end

    tx_unshift u_tx_unshift (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load_tx),
        .i_data (bus.aes_result),
        .i_next (w_next_byte),
        .o_byte (w_byte),
        .o_last (w_last)
    );

    // Strobes decode directly from the state, so they are mutually exclusive and low in reset.
    assign bus.read_en     = (r_state == POP);
    assign bus.aes_start   = (r_state == START);
    assign bus.tx_start    = (r_state == SEND);
    assign bus.busy        = (r_state != IDLE);
    assign bus.error       = r_error;
    assign bus.aes_block   = r_aes_block;
    assign bus.tx_byte     = w_byte;
    assign bus.blocks_done = r_blocks_done;

endmodule
